// File: rtl/ps2_scan_if.sv
// PS/2 pin inputs and decoded scan-code outputs of the scan sequencer.
// The master side is the sequencer; the slave side drives the pins and consumes codes.
interface ps2_scan_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code_out;
    logic       code_valid;
    logic       shift_en;
    logic       is_break;
    logic       is_extended;
    logic       frame_err;
    logic       busy;

    modport master (
        input  ps2_clk, ps2_data,
        output code_out, code_valid, shift_en, is_break, is_extended, frame_err, busy
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  code_out, code_valid, shift_en, is_break, is_extended, frame_err, busy
    );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// PS/2 keyboard frame receiver with F0/E0 prefix decoding.
// Strobes shift_en once per make code for the downstream scan-code shift register.
module ps2_scan_sequencer #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    ps2_scan_if.master bus
);
    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam logic [7:0]  EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]        clk_sync, data_sync;
    logic              filt_clk;
    logic [FILT_W-1:0] filt_cnt;
    logic              filt_flip, fall, data_s;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              par_ok_q, par_ok_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              break_pend_q, break_pend_d;
    logic              ext_pend_q, ext_pend_d;
    logic [7:0]        code_out_q, code_out_d;
    logic              is_break_q, is_break_d;
    logic              is_ext_q, is_ext_d;
    logic              code_valid_q, code_valid_d;
    logic              shift_en_q, shift_en_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              timeout;

    // Two-flop synchronisers; idle PS/2 lines sit high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
        end
    end

    // Level filter: a new ps2_clk level needs FILTER_LEN consecutive agreeing samples
    assign filt_flip = (clk_sync[1] != filt_clk) && (filt_cnt == FILT_W'(FILTER_LEN - 1));
    assign fall      = filt_flip && filt_clk;
    assign data_s    = data_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_ok_q     <= 1'b0;
            to_cnt_q     <= '0;
            break_pend_q <= 1'b0;
            ext_pend_q   <= 1'b0;
            code_out_q   <= '0;
            is_break_q   <= 1'b0;
            is_ext_q     <= 1'b0;
            code_valid_q <= 1'b0;
            shift_en_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_ok_q     <= par_ok_d;
            to_cnt_q     <= to_cnt_d;
            break_pend_q <= break_pend_d;
            ext_pend_q   <= ext_pend_d;
            code_out_q   <= code_out_d;
            is_break_q   <= is_break_d;
            is_ext_q     <= is_ext_d;
            code_valid_q <= code_valid_d;
            shift_en_q   <= shift_en_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    // A falling edge in the same cycle as the timeout keeps the frame alive
    assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_ok_d     = par_ok_q;
        break_pend_d = break_pend_q;
        ext_pend_d   = ext_pend_q;
        code_out_d   = code_out_q;
        is_break_d   = is_break_q;
        is_ext_d     = is_ext_q;
        code_valid_d = 1'b0;
        shift_en_d   = 1'b0;
        frame_err_d  = 1'b0;
        to_cnt_d     = (fall || state_q == IDLE) ? '0 : to_cnt_q + TO_W'(1);

        case (state_q)
            IDLE: begin
                if (fall && !data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_d   = {data_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_ok_d = (^shreg_q) ^ data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_s && par_ok_q) begin
                        if (shreg_q == BREAK_CODE) begin
                            break_pend_d = 1'b1;
                        end else if (shreg_q == EXT_CODE) begin
                            ext_pend_d = 1'b1;
                        end else begin
                            code_out_d   = shreg_q;
                            is_break_d   = break_pend_q;
                            is_ext_d     = ext_pend_q;
                            code_valid_d = 1'b1;
                            shift_en_d   = !break_pend_q;
                            break_pend_d = 1'b0;
                            ext_pend_d   = 1'b0;
                        end
                    end else begin
                        frame_err_d  = 1'b1;
                        break_pend_d = 1'b0;
                        ext_pend_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d      = IDLE;
            frame_err_d  = 1'b1;
            break_pend_d = 1'b0;
            ext_pend_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.code_out    = code_out_q;
    assign bus.code_valid  = code_valid_q;
    assign bus.shift_en    = shift_en_q;
    assign bus.is_break    = is_break_q;
    assign bus.is_extended = is_ext_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: directed cases followed by random frames.
// A keyboard-level model predicts code/error events; a monitor pops them on every output pulse.
module tb_ps2_scan_sequencer;
    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned TIMEOUT    = 2000;
    localparam int unsigned HALF       = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_scan_if bus();

    ps2_scan_sequencer #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         brk;
        bit         ext;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    bit  m_break = 1'b0;
    bit  m_ext   = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Keyboard-level model: what a complete frame should cause downstream
    function automatic void model_frame(logic [7:0] b, bit ok);
        ev_t e;
        if (!ok) begin
            e = '{is_err: 1'b1, code: 8'h00, brk: 1'b0, ext: 1'b0};
            exp_q.push_back(e);
            m_break = 1'b0;
            m_ext   = 1'b0;
        end else if (b == 8'hF0) begin
            m_break = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            e = '{is_err: 1'b0, code: b, brk: m_break, ext: m_ext};
            exp_q.push_back(e);
            m_break = 1'b0;
            m_ext   = 1'b0;
        end
    endfunction

    task automatic wait_clk(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(bit b);
        bus.ps2_data = b;
        wait_clk(HALF);
        bus.ps2_clk = 1'b0;
        wait_clk(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic wait_drain(int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            wait_clk(1);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic send_frame(logic [7:0] b, bit bad_par, bit bad_stop);
        logic par;
        model_frame(b, !(bad_par || bad_stop));
        par = (~^b) ^ bad_par;
        send_bit(1'b0);
        chk("busy_mid_frame", bus.busy, 1);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(!bad_stop);
        bus.ps2_data = 1'b1;
        wait_clk(HALF);
        wait_drain(100);
    endtask

    task automatic check_cleared(string tag);
        chk({tag, "_code_out"}, bus.code_out, 0);
        chk({tag, "_code_valid"}, bus.code_valid, 0);
        chk({tag, "_shift_en"}, bus.shift_en, 0);
        chk({tag, "_is_break"}, bus.is_break, 0);
        chk({tag, "_is_extended"}, bus.is_extended, 0);
        chk({tag, "_frame_err"}, bus.frame_err, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    // Monitor: every output pulse must match the oldest predicted event
    bit prev_cv = 1'b0;
    bit prev_fe = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            prev_cv = 1'b0;
            prev_fe = 1'b0;
        end else begin
            if (bus.code_valid || bus.frame_err || bus.shift_en) begin
                chk("pulse_width", {30'd0, prev_cv & bus.code_valid, prev_fe & bus.frame_err}, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: cv=%b fe=%b se=%b code=%h, expected no pulse",
                             bus.code_valid, bus.frame_err, bus.shift_en, bus.code_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_err", bus.frame_err, e.is_err);
                    chk("code_valid", bus.code_valid, !e.is_err);
                    if (e.is_err) begin
                        chk("shift_en_on_err", bus.shift_en, 0);
                    end else begin
                        chk("code_out", bus.code_out, e.code);
                        chk("is_break", bus.is_break, e.brk);
                        chk("is_extended", bus.is_extended, e.ext);
                        chk("shift_en", bus.shift_en, !e.brk);
                    end
                end
            end
            prev_cv = bus.code_valid;
            prev_fe = bus.frame_err;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         r;
        logic [7:0] b;
        bit         bp, bs;
        logic [7:0] g;

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        wait_clk(3);
        check_cleared("reset");
        reset = 1'b0;
        wait_clk(5);

        // Plain make code, then break, extended and extended break sequences
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);

        // Bad parity, and a bad frame clearing a pending break
        send_frame(8'h1C, 1, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h33, 0, 1);
        send_frame(8'h1C, 0, 0);

        // Timeout after 4 data bits; a pending break must also be dropped
        send_frame(8'hF0, 0, 0);
        model_frame(8'h29, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_clk(TIMEOUT + 50);
        wait_drain(10);
        chk("busy_after_timeout", bus.busy, 0);
        send_frame(8'h29, 0, 0);

        // Reset after 5 data bits discards the frame and the pending extension
        send_frame(8'hE0, 0, 0);
        b = 8'h4B;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(b[i]);
        reset = 1'b1;
        #1;
        m_break = 1'b0;
        m_ext   = 1'b0;
        check_cleared("midreset");
        wait_clk(3);
        reset = 1'b0;
        wait_clk(5);
        send_frame(8'h1C, 0, 0);

        // Short ps2_clk glitch mid-frame must not be counted as an edge
        g = 8'h5A;
        model_frame(g, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(g[i]);
        bus.ps2_clk = 1'b0;
        wait_clk(FILTER_LEN - 1);
        bus.ps2_clk = 1'b1;
        wait_clk(2);
        for (int i = 3; i < 8; i++) send_bit(g[i]);
        send_bit(~^g);
        send_bit(1'b1);
        wait_clk(HALF);
        wait_drain(100);

        // Random traffic with prefixes and occasional corrupted frames
        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 15));
            b  = 8'($urandom);
            if (r < 3) b = 8'hF0;
            else if (r < 5) b = 8'hE0;
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 15) == 0);
            send_frame(b, bp, bs);
        end

        wait_clk(20);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
